// File: rtl/aes_bist_pkg.sv
// Shared types, limits and the known-answer table for the AES-128 decryption self-test.
// Vector 7 reuses vector 0's key/ct with a deliberately wrong expected plaintext.
package aes_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORE_RST,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_COMPARE,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } kat_t;

    localparam int unsigned TIMEOUT_MIN  = 2;
    localparam int unsigned TIMEOUT_MAX  = 255;
    localparam int unsigned RST_HOLD_MIN = 1;
    localparam int unsigned RST_HOLD_MAX = 15;

    localparam logic [2:0] LAST_VECTOR = 3'd7;
    localparam logic [3:0] FAIL_SAT    = 4'd8;

    localparam logic [127:0] KEY_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    function automatic kat_t kat_lookup(input logic [2:0] index);
        kat_t entry;
        case (index)
            3'd0:    entry = '{key: KEY_B,    ct: CT_B,  pt: PT_B};
            3'd1:    entry = '{key: KEY_C1,   ct: CT_C1, pt: PT_C1};
            3'd2:    entry = '{key: KEY_B,
                               ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                               pt: 128'h6bc1bee22e409f96e93d7e117393172a};
            3'd3:    entry = '{key: KEY_B,
                               ct: 128'hf5d3d585503b9699de785895a96fdbaf,
                               pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};
            3'd4:    entry = '{key: KEY_B,
                               ct: 128'h43b1cd7f598ece23881b00e3ed030688,
                               pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef};
            3'd5:    entry = '{key: KEY_B,
                               ct: 128'h7b0c785e27e8ad3f8223207104725dd4,
                               pt: 128'hf69f2445df4f9b17ad2b417be66c3710};
            3'd6:    entry = '{key: KEY_ZERO,
                               ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                               pt: 128'h0};
            // Comparator self-check: a correct core must NOT match this plaintext.
            3'd7:    entry = '{key: KEY_B, ct: CT_B, pt: PT_B ^ 128'h1};
            default: entry = '{key: 128'h0, ct: 128'h0, pt: 128'h0};
        endcase
        return entry;
    endfunction

    function automatic logic [3:0] fail_inc(input logic [3:0] count);
        if (count >= FAIL_SAT) begin
            return FAIL_SAT;
        end else begin
            return count + 4'd1;
        end
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational known-answer table: vector index -> {key, ct, pt}.
module aes_kat_rom
    import aes_bist_pkg::*;
(
    input  logic [2:0] index,
    output kat_t       entry
);

    // Table lookup
    always_comb begin
        entry = kat_lookup(index);
    end

endmodule

// File: rtl/aes_dec_bist.sv
// Self-test sequencer driving known-answer vectors through an external AES-128 decryption core.
// Resets the core before every vector so a hung core is recovered after a timeout.
module aes_dec_bist
    import aes_bist_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RST_HOLD       = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Run,
    input  logic         Sweep,
    input  logic [2:0]   Vec_Sel,
    output logic         Core_RST_n,
    output logic         Core_En,
    output logic [127:0] Core_CT,
    output logic [127:0] Core_KEY,
    input  logic [127:0] Core_PT,
    input  logic         Core_Valid,
    output logic         Busy,
    output logic         Done,
    output logic         Pass,
    output logic [3:0]   Fail_Count,
    output logic [7:0]   Result_Map,
    output logic         Timeout_Err
);

    localparam int unsigned TO_EFF   = (TIMEOUT_CYCLES < TIMEOUT_MIN) ? TIMEOUT_MIN :
                                       ((TIMEOUT_CYCLES > TIMEOUT_MAX) ? TIMEOUT_MAX : TIMEOUT_CYCLES);
    localparam int unsigned HOLD_EFF = (RST_HOLD < RST_HOLD_MIN) ? RST_HOLD_MIN :
                                       ((RST_HOLD > RST_HOLD_MAX) ? RST_HOLD_MAX : RST_HOLD);
    localparam logic [7:0] TO_LAST     = 8'(TO_EFF - 1);
    localparam logic [3:0] HOLD_CYCLES = 4'(HOLD_EFF);

    state_t         state_r;
    logic           sweep_r;
    logic [2:0]     index_r;
    logic [3:0]     hold_cnt_r;
    logic [7:0]     wait_cnt_r;
    logic [127:0]   pt_cap_r;
    kat_t           rom_entry_s;
    logic           vector_ok_s;

    aes_kat_rom u_rom (
        .index (index_r),
        .entry (rom_entry_s)
    );

    // Vector 7 passes only when the comparator reports a mismatch
    always_comb begin
        if (index_r == LAST_VECTOR) begin
            vector_ok_s = (pt_cap_r != rom_entry_s.pt);
        end else begin
            vector_ok_s = (pt_cap_r == rom_entry_s.pt);
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            sweep_r     <= 1'b0;
            index_r     <= 3'd0;
            hold_cnt_r  <= 4'd0;
            wait_cnt_r  <= 8'd0;
            pt_cap_r    <= 128'h0;
            Core_RST_n  <= 1'b0;
            Core_En     <= 1'b0;
            Core_CT     <= 128'h0;
            Core_KEY    <= 128'h0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            Fail_Count  <= 4'd0;
            Result_Map  <= 8'd0;
            Timeout_Err <= 1'b0;
        end else begin
            Core_En    <= 1'b0;
            Core_RST_n <= 1'b1;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Run) begin
                        sweep_r     <= Sweep;
                        index_r     <= Sweep ? 3'd0 : Vec_Sel;
                        Fail_Count  <= 4'd0;
                        Result_Map  <= 8'd0;
                        Timeout_Err <= 1'b0;
                        Done        <= 1'b0;
                        Pass        <= 1'b0;
                        Busy        <= 1'b1;
                        hold_cnt_r  <= 4'd0;
                        state_r     <= ST_CORE_RST;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CORE_RST: begin
                    if (hold_cnt_r == HOLD_CYCLES) begin
                        state_r <= ST_LOAD;
                    end else begin
                        Core_RST_n <= 1'b0;
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end
                end
                ST_LOAD: begin
                    Core_CT  <= rom_entry_s.ct;
                    Core_KEY <= rom_entry_s.key;
                    state_r  <= ST_START;
                end
                ST_START: begin
                    Core_En    <= 1'b1;
                    wait_cnt_r <= 8'd0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Core_Valid) begin
                        pt_cap_r <= Core_PT;
                        state_r  <= ST_COMPARE;
                    end else if (wait_cnt_r == TO_LAST) begin
                        Timeout_Err <= 1'b1;
                        Fail_Count  <= fail_inc(Fail_Count);
                        state_r     <= ST_NEXT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_COMPARE: begin
                    if (vector_ok_s) begin
                        Result_Map[index_r] <= 1'b1;
                    end else begin
                        Fail_Count <= fail_inc(Fail_Count);
                    end
                    state_r <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (sweep_r && (index_r != LAST_VECTOR)) begin
                        index_r    <= index_r + 3'd1;
                        hold_cnt_r <= 4'd0;
                        state_r    <= ST_CORE_RST;
                    end else begin
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Pass    <= (Fail_Count == 4'd0);
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    Busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_bist.sv
// Scoreboard bench for aes_dec_bist with a behavioural decryption-core model.
module tb_aes_dec_bist;

    localparam int HOLD = 2;

    logic         CLK = 1'b0;
    logic         RST, Run, Sweep;
    logic [2:0]   Vec_Sel;
    logic         Core_RST_n, Core_En, Core_Valid;
    logic [127:0] Core_CT, Core_KEY, Core_PT;
    logic         Busy, Done, Pass, Timeout_Err;
    logic [3:0]   Fail_Count;
    logic [7:0]   Result_Map;

    aes_dec_bist #(.TIMEOUT_CYCLES(64), .RST_HOLD(HOLD)) dut (
        .CLK(CLK), .RST(RST), .Run(Run), .Sweep(Sweep), .Vec_Sel(Vec_Sel),
        .Core_RST_n(Core_RST_n), .Core_En(Core_En), .Core_CT(Core_CT), .Core_KEY(Core_KEY),
        .Core_PT(Core_PT), .Core_Valid(Core_Valid), .Busy(Busy), .Done(Done), .Pass(Pass),
        .Fail_Count(Fail_Count), .Result_Map(Result_Map), .Timeout_Err(Timeout_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] map;
        logic [3:0] fail;
        logic       to;
        logic       pass;
        int         n_en;
        int         n_rst_lo;
        int         lat;
    } exp_t;

    logic [127:0] kat_key [8];
    logic [127:0] kat_ct  [8];
    logic [127:0] kat_pt  [8];

    exp_t sb_q[$];
    int   ct_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   core_lat = 11;
    int   corrupt_vec = -1;
    int   corrupt_bit = 0;
    int   drop_vec = -1;
    bit   spurious = 1'b0;
    int   en_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_core_rst_n"}, Core_RST_n, 0);
        chk({tag, "_core_en"}, Core_En, 0);
        chk({tag, "_core_ct"}, Core_CT, 0);
        chk({tag, "_core_key"}, Core_KEY, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_pass"}, Pass, 0);
        chk({tag, "_fail_count"}, Fail_Count, 0);
        chk({tag, "_result_map"}, Result_Map, 0);
        chk({tag, "_timeout_err"}, Timeout_Err, 0);
    endtask

    // True AES decryption for the known ciphertexts; -1 when unknown
    function automatic int ct_to_vec(input logic [127:0] ct);
        for (int v = 0; v < 7; v++) begin
            if (kat_ct[v] == ct) return v;
        end
        return -1;
    endfunction

    // Behavioural core: Valid pulses core_lat cycles after En, reset cancels
    initial begin : core_model
        int cnt;
        int v;
        logic [127:0] pend;
        logic rstn_q;
        cnt = -1;
        pend = '0;
        rstn_q = 1'b0;
        Core_Valid = 1'b0;
        Core_PT = '0;
        forever begin
            @(negedge CLK);
            Core_Valid = 1'b0;
            if (!Core_RST_n) begin
                cnt = -1;
            end else begin
                if (spurious && !rstn_q) begin
                    Core_Valid = 1'b1;
                    Core_PT = {$urandom, $urandom, $urandom, $urandom};
                end
                if (Core_En) begin
                    v = ct_to_vec(Core_CT);
                    if (v >= 0 && v == drop_vec) begin
                        cnt = -1;
                    end else begin
                        pend = (v >= 0) ? kat_pt[v] : 128'h0;
                        if (v >= 0 && v == corrupt_vec) pend[corrupt_bit] = ~pend[corrupt_bit];
                        cnt = core_lat;
                    end
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        Core_Valid = 1'b1;
                        Core_PT = pend;
                        cnt = -1;
                    end
                end
            end
            rstn_q = Core_RST_n;
        end
    end

    // Monitor: checks Core_En payloads and pops run results when Done rises
    always @(negedge CLK) begin : monitor
        int   neg_cnt, run_neg, rst_lo, v;
        logic busy_q, done_q;
        exp_t e;
        neg_cnt++;
        if (Busy && !busy_q) begin
            run_neg = neg_cnt;
            en_cnt = 0;
            rst_lo = 0;
        end
        if (Busy && !Core_RST_n) rst_lo++;
        if (Core_En) begin
            en_cnt++;
            if (ct_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_core_en: got pulse expected none");
            end else begin
                v = ct_q.pop_front();
                chk("core_ct", Core_CT, kat_ct[v]);
                chk("core_key", Core_KEY, kat_key[v]);
            end
        end
        if (Done && !done_q) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_done: got Done expected none");
            end else begin
                e = sb_q.pop_front();
                chk("result_map", Result_Map, e.map);
                chk("fail_count", Fail_Count, e.fail);
                chk("timeout_err", Timeout_Err, e.to);
                chk("pass", Pass, e.pass);
                chk("busy_at_done", Busy, 0);
                chk("en_pulses", en_cnt, e.n_en);
                chk("core_rst_low_cycles", rst_lo, e.n_rst_lo);
                if (e.lat >= 0) chk("done_latency", neg_cnt - run_neg, e.lat);
            end
        end
        busy_q = Busy;
        done_q = Done;
    end

    task automatic do_run(input bit sweep, input logic [2:0] sel, input bit check_lat, input bit busy_runs);
        exp_t e;
        int n, v, k;
        logic [127:0] out;
        bit ok, seen;
        e.map = '0; e.fail = '0; e.to = 1'b0; n = 0;
        for (int i = 0; i < 8; i++) begin
            if (sweep || i == 0) begin
                v = sweep ? i : int'(sel);
                ct_q.push_back(v);
                n++;
                if (v == drop_vec) begin
                    e.fail++;
                    e.to = 1'b1;
                end else begin
                    out = kat_pt[(v == 7) ? 0 : v];
                    if (v == corrupt_vec) out[corrupt_bit] = ~out[corrupt_bit];
                    ok = (v < 7) ? (out == kat_pt[v]) : (out != kat_pt[7]);
                    if (ok) e.map[v] = 1'b1;
                    else    e.fail++;
                end
            end
        end
        e.pass = (e.fail == 4'd0);
        e.n_en = n;
        e.n_rst_lo = n * HOLD;
        e.lat = check_lat ? (HOLD + 3 + core_lat + 3) : -1;
        sb_q.push_back(e);
        @(negedge CLK);
        Run = 1'b1; Sweep = sweep; Vec_Sel = sel;
        @(negedge CLK);
        Run = 1'b0; Sweep = 1'($urandom); Vec_Sel = 3'($urandom);
        seen = 1'b0;
        for (k = 0; k < 4000 && !seen; k++) begin
            @(negedge CLK);
            if (Done) begin
                seen = 1'b1;
                Run = 1'b0;
            end else begin
                Run = busy_runs && ($urandom_range(0, 5) == 0);
                Sweep = 1'($urandom);
                Vec_Sel = 3'($urandom);
            end
        end
        Run = 1'b0;
        if (!seen) begin
            n_checks++; n_err++;
            $display("FAIL done_wait: got no Done expected Done within 4000 cycles");
            sb_q.delete();
            ct_q.delete();
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        kat_key[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        kat_ct[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
        kat_pt[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        kat_key[1] = 128'h000102030405060708090a0b0c0d0e0f;
        kat_ct[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat_pt[1]  = 128'h00112233445566778899aabbccddeeff;
        kat_ct[2]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        kat_pt[2]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        kat_ct[3]  = 128'hf5d3d585503b9699de785895a96fdbaf;
        kat_pt[3]  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        kat_ct[4]  = 128'h43b1cd7f598ece23881b00e3ed030688;
        kat_pt[4]  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        kat_ct[5]  = 128'h7b0c785e27e8ad3f8223207104725dd4;
        kat_pt[5]  = 128'hf69f2445df4f9b17ad2b417be66c3710;
        for (int i = 2; i < 6; i++) kat_key[i] = kat_key[0];
        kat_key[6] = 128'h0;
        kat_ct[6]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        kat_pt[6]  = 128'h0;
        kat_key[7] = kat_key[0];
        kat_ct[7]  = kat_ct[0];
        kat_pt[7]  = kat_pt[0] ^ 128'h1;

        RST = 1'b1; Run = 1'b0; Sweep = 1'b0; Vec_Sel = 3'd0;
        repeat (3) @(negedge CLK);
        chk_reset_values("por");
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_core_rst_n", Core_RST_n, 1);

        do_run(1'b1, 3'd0, 1'b0, 1'b0);
        do_run(1'b0, 3'd1, 1'b1, 1'b0);
        corrupt_vec = 3; corrupt_bit = 5;
        do_run(1'b1, 3'd0, 1'b0, 1'b0);
        corrupt_vec = -1;
        drop_vec = 4;
        do_run(1'b1, 3'd0, 1'b0, 1'b0);
        drop_vec = -1;
        spurious = 1'b1;
        do_run(1'b1, 3'd0, 1'b0, 1'b1);
        spurious = 1'b0;

        // Abort in WAIT of vector 2
        for (int i = 0; i < 8; i++) ct_q.push_back(i);
        @(negedge CLK); Run = 1'b1; Sweep = 1'b1;
        @(negedge CLK); Run = 1'b0;
        @(negedge CLK);
        k = 0;
        while (en_cnt < 3 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        chk("abort_reached_vec2", (en_cnt >= 3), 1);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_reset_values("abort");
        ct_q.delete();
        @(negedge CLK);
        chk("abort_idle_core_rst_n", Core_RST_n, 1);
        do_run(1'b1, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            core_lat = $urandom_range(1, 20);
            corrupt_vec = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1;
            corrupt_bit = $urandom_range(0, 127);
            do_run(1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        end
        core_lat = $urandom_range(1, 20);
        corrupt_vec = $urandom_range(1, 6);
        corrupt_bit = $urandom_range(0, 127);
        drop_vec = $urandom_range(1, 6);
        do_run(1'b1, 3'd0, 1'b0, 1'b0);
        corrupt_vec = -1;
        drop_vec = -1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
